reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Write-back destination for the multi-cycle datapath: a 32 x 32 general-purpose register file.
- Consumes the 5-bit destination index chosen upstream from rd, rt or 31, decodes it to one-hot write enables, and stores the write-back word.
- Provides two asynchronous operand read ports (rs, rt) and a third debug read port for the display/debug path.
- Registers a one-cycle echo of each committed write for debug and trace.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; the depth is 2**AW.
- BYPASS, 0, 1 = a same-cycle write is forwarded to the read ports; 0 = read returns stored contents only.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst_n  in  1  synchronous reset, active-low.
- we  in  1  write-back enable (RegWrite from control FSM).
- waddr  in  AW  destination register index (output of the destination-select mux).
- wdata  in  DW  write-back data.
- raddr_a  in  AW  read port A index (rs).
- rdata_a  out  DW  read port A data.
- raddr_b  in  AW  read port B index (rt).
- rdata_b  out  DW  read port B data.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  DW  debug read data; never bypassed.
- wb_valid  out  1  pulses high the cycle after a write is committed.
- wb_addr  out  AW  index of the last committed write.
- wb_data  out  DW  data of the last committed write.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, regs[1..31] <= 0, wb_valid <= 0, wb_addr <= 0, wb_data <= 0. Reset has priority over any concurrent write.
- Reset mid-operation: a write presented in a reset cycle is discarded.
- Decode: waddr feeds a 5-to-32 one-hot decoder gated by we.
- Commit condition: a write is committed when rst_n=1, we=1 and waddr!=0. The decoder line for index 0 is forced low.
- Write: on a committed write, regs[waddr] <= wdata at the rising edge; the value is visible to reads in the next cycle.
- Register 0: reads always return 0. Writes to index 0 are dropped silently and produce no wb_valid pulse.
- Reads: rdata_a, rdata_b and dbg_data are combinational, with zero latency from the address.
- Index 0 on any read port returns 0.
- Bypass, BYPASS=1: when we=1, waddr!=0 and raddr_x==waddr, rdata_x = wdata in the same cycle.
- Bypass, BYPASS=0: rdata_x returns the old contents until the edge.
- Bypass never applies to dbg_data, and never while rst_n=0. While rst_n=0, reads return stored contents with no bypass.
- Simultaneous reads: raddr_a==raddr_b is legal and both ports return the same value.
- Echo: wb_valid <= committed write, registered. wb_addr/wb_data update only on a committed write and otherwise hold their values. wb_valid returns to 0 in the following cycle unless another write commits.
- Consecutive writes to the same index in back-to-back cycles: the last write wins, and wb_valid stays high for both cycles.
- There are no X outputs after the first reset edge.

Decomposition:
- Shared package (regfile_pkg):
  - REG_ZERO = 5'd0 and REG_RA = 5'd31.
  - Default DW/AW constants.
  - typedef reg_idx_t (logic [4:0]) and word_t (logic [31:0]), shared with the destination-select mux and the control FSM.
- Sub-module decoder_5to32: combinational one-hot decoder with enable (inputs en, a[4:0]; output y[31:0]). It is the inverse of the destination-select mux, instantiated once for the write enables.
- Register array, read muxing, bypass and echo logic stay in reg_file_wb.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then read all 32 indices on port A -> all 0; wb_valid=0.
- Write/readback: we=1, waddr=5'd31, wdata=32'hDEADBEEF for one cycle -> next cycle rdata_b (raddr_b=31)=32'hDEADBEEF; wb_valid=1, wb_addr=31, wb_data=32'hDEADBEEF; the cycle after, wb_valid=0.
- Register 0: we=1, waddr=0, wdata=32'hFFFFFFFF -> rdata_a (raddr_a=0)=0 forever; wb_valid stays 0.
- Bypass: with BYPASS=1, regs[8]=32'h11 and we=1, waddr=8, wdata=32'h22, raddr_a=8 -> rdata_a=32'h22 the same cycle and dbg_data (dbg_addr=8)=32'h11. With BYPASS=0 -> rdata_a=32'h11.
- Reset vs write: rst_n=0 with we=1, waddr=3, wdata=32'h5 -> regs[3]=0 afterwards; wb_valid=0.
- Back-to-back writes: waddr=7 with wdata 32'hA then 32'hB on consecutive cycles -> regs[7]=32'hB; wb_valid high 2 cycles with wb_data 32'hA then 32'hB.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : shared register-index/word types and helper constants  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

    function automatic word_t onehot32(input reg_idx_t idx);
        return 32'd1 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_5to32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decoder_5to32 : combinational 5-to-32 one-hot decoder with enable    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic        en,
    input  reg_idx_t    a,
    output word_t       y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = onehot32(a);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_wb : 2^AW x DW write-back register file, two operand read   |
// |               ports, one debug port, registered write echo. Rev 1.0  |
// +----------------------------------------------------------------------+
module reg_file_wb
    import regfile_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int BYPASS = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DEPTH-1:0] w_dec_line;
    logic [DEPTH-1:0] w_wr_line;
    logic             w_dec_en;
    logic             w_commit;
    logic             w_byp_en;

    logic             wb_valid_q, wb_valid_d;
    logic [AW-1:0]    wb_addr_q,  wb_addr_d;
    logic [DW-1:0]    wb_data_q,  wb_data_d;

    assign w_dec_en = we && rst_n;
    assign w_commit = w_dec_en && (waddr != '0);
    assign w_byp_en = (BYPASS != 0) && w_commit;

    generate
        if (AW == 5) begin : g_dec5
            word_t w_dec_y;
            decoder_5to32 u_dec (
                .en (w_dec_en),
                .a  (waddr),
                .y  (w_dec_y)
            );
            assign w_dec_line = w_dec_y;
        end else begin : g_dec_gen
            for (genvar i = 0; i < DEPTH; i++) begin : g_line
                assign w_dec_line[i] = w_dec_en && (waddr == AW'(i));
            end
        end
    endgenerate

    // Register 0 is hard-wired zero, so its write line never fires.
    assign w_wr_line = w_dec_line & ~DEPTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wr_line[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            rdata_a = (w_byp_en && (raddr_a == waddr)) ? wdata : regs_q[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            rdata_b = (w_byp_en && (raddr_b == waddr)) ? wdata : regs_q[raddr_b];
        end
    end

    // Debug port always shows committed state, never the in-flight write.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    always_comb begin
        wb_valid_d = w_commit;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (w_commit) begin
            wb_addr_d = waddr;
            wb_data_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_wb : vector table + echo scoreboard for reg_file_wb,     |
// |                  one instance per bypass setting. Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr, raddr_a, raddr_b, dbg_addr;
    logic [31:0] wdata;

    logic [31:0] rdata_a0, rdata_b0, dbg_data0, wb_data0;
    logic [31:0] rdata_a1, rdata_b1, dbg_data1, wb_data1;
    logic [4:0]  wb_addr0, wb_addr1;
    logic        wb_valid0, wb_valid1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb, dg;
        logic [31:0] ea0, ea1, eb0, eb1, ed;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_wb #(.DW(32), .AW(5), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data0),
        .wb_valid(wb_valid0), .wb_addr(wb_addr0), .wb_data(wb_data0)
    );

    reg_file_wb #(.DW(32), .AW(5), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data1),
        .wb_valid(wb_valid1), .wb_addr(wb_addr1), .wb_data(wb_data1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the edge; return at the following negedge.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        @(posedge clk);
        #1;
        rst_n = r; we = w; waddr = wa; wdata = wd;
        raddr_a = a; raddr_b = b; dbg_addr = d;
        if (r && w && (wa != 5'd0)) sb.push_back('{cyc + 1, wa, wd});
        @(negedge clk);
    endtask

    // Echo monitor: a pulse is required exactly in the cycle after each committed write.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_v;
            sb_t  e;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            chk("wb_valid bypass0", {31'd0, wb_valid0}, {31'd0, exp_v});
            chk("wb_valid bypass1", {31'd0, wb_valid1}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                chk("wb_addr bypass0", {27'd0, wb_addr0}, {27'd0, e.a});
                chk("wb_data bypass0", wb_data0, e.d);
                chk("wb_addr bypass1", {27'd0, wb_addr1}, {27'd0, e.a});
                chk("wb_data bypass1", wb_data1, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31, 5'd31, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        tbl[3]  = '{1'b1, 5'd8,  32'h11,       5'd8,  5'd31, 5'd8,  32'h0,        32'h11,       32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b1, 5'd8,  32'h22,       5'd8,  5'd8,  5'd8,  32'h11,       32'h22,       32'h11,       32'h22,       32'h11};
        tbl[5]  = '{1'b0, 5'd8,  32'h33,       5'd8,  5'd8,  5'd8,  32'h22,       32'h22,       32'h22,       32'h22,       32'h22};
        tbl[6]  = '{1'b1, 5'd7,  32'hA,        5'd7,  5'd8,  5'd7,  32'h0,        32'hA,        32'h22,       32'h22,       32'h0};
        tbl[7]  = '{1'b1, 5'd7,  32'hB,        5'd7,  5'd7,  5'd7,  32'hA,        32'hB,        32'hA,        32'hB,        32'hA};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'hB,        32'hB,        32'hB,        32'hB,        32'hB};
        tbl[9]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd6,  5'd0,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};

        rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h5;
        raddr_a = '0; raddr_b = '0; dbg_addr = '0;

        // Reset held two cycles with a write pending that must be discarded.
        drive(1'b0, 1'b1, 5'd3, 32'h5, 5'd3, 5'd3, 5'd3);
        mon_en = 1'b1;
        drive(1'b0, 1'b1, 5'd3, 32'h5, 5'd3, 5'd3, 5'd3);
        chk("reset wb_addr", {27'd0, wb_addr0}, 32'h0);
        chk("reset wb_data", wb_data1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
            chk($sformatf("reset sweep a0 r%0d", i), rdata_a0, 32'h0);
            chk($sformatf("reset sweep a1 r%0d", i), rdata_a1, 32'h0);
        end

        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].dg);
            chk($sformatf("v%0d rdata_a bypass0", i), rdata_a0, tbl[i].ea0);
            chk($sformatf("v%0d rdata_a bypass1", i), rdata_a1, tbl[i].ea1);
            chk($sformatf("v%0d rdata_b bypass0", i), rdata_b0, tbl[i].eb0);
            chk($sformatf("v%0d rdata_b bypass1", i), rdata_b1, tbl[i].eb1);
            chk($sformatf("v%0d dbg bypass0", i), dbg_data0, tbl[i].ed);
            chk($sformatf("v%0d dbg bypass1", i), dbg_data1, tbl[i].ed);
        end

        // Echo registers hold the last committed write while idle.
        drive(1'b1, 1'b1, 5'd9, 32'h77, 5'd9, 5'd9, 5'd9);
        chk("hold pre a0", rdata_a0, 32'h0);
        chk("hold pre a1", rdata_a1, 32'h77);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9);
        chk("hold wb_addr0", {27'd0, wb_addr0}, 32'd9);
        chk("hold wb_data0", wb_data0, 32'h77);
        chk("hold wb_addr1", {27'd0, wb_addr1}, 32'd9);
        chk("hold wb_data1", wb_data1, 32'h77);
        chk("hold rd a0", rdata_a0, 32'h77);

        // Mid-operation reset: no bypass during reset, write dropped, echo cleared.
        drive(1'b0, 1'b1, 5'd7, 32'h99, 5'd7, 5'd7, 5'd7);
        chk("rst-mid a0", rdata_a0, 32'hB);
        chk("rst-mid a1", rdata_a1, 32'hB);
        chk("rst-mid b1", rdata_b1, 32'hB);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 5'd9);
        chk("post-rst a0", rdata_a0, 32'h0);
        chk("post-rst b1", rdata_b1, 32'h0);
        chk("post-rst dbg0", dbg_data0, 32'h0);
        chk("post-rst wb_addr1", {27'd0, wb_addr1}, 32'h0);
        chk("post-rst wb_data0", wb_data0, 32'h0);

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
